fb_pixel_writer: RTL

Framebuffer write stage sitting directly downstream of the shape renderers. It consumes the renderer's pixel stream (x, y, cidx, drawing) and throttles it through oe. Each pixel is clipped to the screen, converted to a linear framebuffer address and buffered in a small FIFO so memory backpressure never drops pixels. It also performs a full-screen clear to a background colour index on request.

---
 rtl/fb_pixel_writer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fb_pixel_writer.sv
// Framebuffer write stage: clips renderer pixels, converts them to linear addresses,
// buffers them in a small show-ahead FIFO and performs full-screen clears on request.
module fb_pixel_writer #(
  parameter int CORDW      = 16,
  parameter int CIDXW      = 4,
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 180,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDRW      = $clog2(WIDTH*HEIGHT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [CORDW-1:0] x_i,
  input  logic signed [CORDW-1:0] y_i,
  input  logic [CIDXW-1:0]        cidx_i,
  input  logic                    drawing_i,
  output logic                    oe_o,
  input  logic                    clear_i,
  input  logic [CIDXW-1:0]        clear_cidx_i,
  output logic                    fb_we_o,
  output logic [ADDRW-1:0]        fb_addr_o,
  output logic [CIDXW-1:0]        fb_cidx_o,
  input  logic                    fb_ready_i,
  output logic                    busy_o,
  output logic                    clear_done_o,
  output logic [15:0]             clip_cnt_o
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam logic [ADDRW-1:0]        LAST_ADDR = ADDRW'(WIDTH*HEIGHT-1);
  localparam logic signed [CORDW-1:0] WIDTH_S   = CORDW'(WIDTH);
  localparam logic signed [CORDW-1:0] HEIGHT_S  = CORDW'(HEIGHT);
  localparam logic [CNTW-1:0]         DEPTH_C   = CNTW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDRW-1:0]  clr_addr_q, clr_addr_d;
  logic [CIDXW-1:0]  clr_cidx_q, clr_cidx_d;
  logic              clear_done_q, clear_done_d;
  logic [15:0]       clip_cnt_q, clip_cnt_d;

  logic [ADDRW-1:0]  addr_mem_q [FIFO_DEPTH];
  logic [CIDXW-1:0]  cidx_mem_q [FIFO_DEPTH];
  logic [PTRW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]   count_q, count_d;

  logic              accept_s;
  logic              in_range_s;
  logic              push_s;
  logic              pop_s;
  logic [ADDRW-1:0]  pix_addr_s;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PASS;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus clear-sequencer next values
  always_comb begin
    state_d      = state_q;
    clr_addr_d   = clr_addr_q;
    clr_cidx_d   = clr_cidx_q;
    clear_done_d = 1'b0;
    case (state_q)
      PASS: begin
        if (clear_i) begin
          clr_cidx_d = clear_cidx_i;
          state_d    = DRAIN;
        end else begin
          state_d = PASS;
        end
      end
      DRAIN: begin
        if (count_q == {CNTW{1'b0}}) begin
          clr_addr_d = {ADDRW{1'b0}};
          state_d    = CLEAR;
        end else begin
          state_d = DRAIN;
        end
      end
      CLEAR: begin
        if (fb_ready_i) begin
          if (clr_addr_q == LAST_ADDR) begin
            clear_done_d = 1'b1;
            state_d      = PASS;
          end else begin
            clr_addr_d = clr_addr_q + ADDRW'(1);
          end
        end else begin
          state_d = CLEAR;
        end
      end
      default: begin
        state_d = PASS;
      end
    endcase
  end

  // Outputs, all derived from registered state
  always_comb begin
    oe_o   = (state_q == PASS) && (count_q < DEPTH_C);
    busy_o = (state_q != PASS) || (count_q != {CNTW{1'b0}});
    if (state_q == CLEAR) begin
      fb_we_o   = 1'b1;
      fb_addr_o = clr_addr_q;
      fb_cidx_o = clr_cidx_q;
    end else if (count_q != {CNTW{1'b0}}) begin
      fb_we_o   = 1'b1;
      fb_addr_o = addr_mem_q[rd_ptr_q];
      fb_cidx_o = cidx_mem_q[rd_ptr_q];
    end else begin
      fb_we_o   = 1'b0;
      fb_addr_o = {ADDRW{1'b0}};
      fb_cidx_o = {CIDXW{1'b0}};
    end
  end

  assign clear_done_o = clear_done_q;
  assign clip_cnt_o   = clip_cnt_q;

  // Pixel acceptance, clipping and FIFO bookkeeping
  always_comb begin
    accept_s   = drawing_i && oe_o;
    in_range_s = (x_i >= $signed({CORDW{1'b0}})) && (x_i < WIDTH_S) &&
                 (y_i >= $signed({CORDW{1'b0}})) && (y_i < HEIGHT_S);
    push_s     = accept_s && in_range_s;
    pop_s      = (state_q != CLEAR) && (count_q != {CNTW{1'b0}}) && fb_ready_i;
    // Out-of-range values produce a meaningless address but are never pushed
    pix_addr_s = ADDRW'(y_i) * ADDRW'(WIDTH) + ADDRW'(x_i);
    wr_ptr_d   = push_s ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
    rd_ptr_d   = pop_s  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    if (accept_s && !in_range_s && (clip_cnt_q != 16'hFFFF)) begin
      clip_cnt_d = clip_cnt_q + 16'd1;
    end else begin
      clip_cnt_d = clip_cnt_q;
    end
  end

  // FIFO storage, contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push_s) begin
      addr_mem_q[wr_ptr_q] <= pix_addr_s;
      cidx_mem_q[wr_ptr_q] <= cidx_i;
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= {PTRW{1'b0}};
      rd_ptr_q     <= {PTRW{1'b0}};
      count_q      <= {CNTW{1'b0}};
      clr_addr_q   <= {ADDRW{1'b0}};
      clr_cidx_q   <= {CIDXW{1'b0}};
      clear_done_q <= 1'b0;
      clip_cnt_q   <= 16'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      clr_addr_q   <= clr_addr_d;
      clr_cidx_q   <= clr_cidx_d;
      clear_done_q <= clear_done_d;
      clip_cnt_q   <= clip_cnt_d;
    end
  end

endmodule
